o_pixel_packer: RTL and testbench
=================================

Name: o_pixel_packer

Overview:
- Downstream of the oscilloscope timing counter. Samples the scope's serial video data at each visible pixel, using the counter's pixel coordinates and visible flag.
- Packs pixels into 16-bit words, computes each word's frame-buffer address, and queues write requests in a small FIFO.
- The FIFO decouples the scope pixel clock from the frame-buffer write port arbiter.

Parameters:
- PIX_BITS, 1, bits per pixel on O_DATA; legal values 1, 2, 4.
- H_VISIBLE, 576, visible pixels per line; must be a multiple of 16/PIX_BITS.
- V_VISIBLE, 378, visible lines per frame.
- FIFO_DEPTH, 4, write-request FIFO entries; power of 2, minimum 2.
- ADDR_W, 15, frame-buffer word-address width.

Ports:
- O_CLK  in  1  scope pixel clock.
- RST_N  in  1  asynchronous active-low reset.
- O_X  in  10  pixel x from the timing counter (0 = first visible pixel).
- O_Y  in  9  pixel y from the timing counter (0 = first visible line).
- O_VISIBLE  in  1  current pixel lies in the visible window.
- O_DATA  in  PIX_BITS  scope video data for the current pixel.
- FRAME_START  in  1  one-or-more-cycle pulse in vertical blanking (timing counter SYNC).
- WR_VALID  out  1  FIFO head holds a write request.
- WR_READY  in  1  consumer accepts the head this cycle.
- WR_ADDR  out  ADDR_W  word address of the head.
- WR_DATA  out  16  packed pixels; pixel 0 at LSBs.
- OVERFLOW  out  1  sticky: a word was dropped this frame.
- BANK  out  1  current write bank (constant 0 unless DOUBLE_BUFFER_EN).

Behaviour:
- Reset (RST_N low, async): all FIFO pointers, pack shift register, pixel count, pending flag, OVERFLOW and BANK go to 0. WR_VALID=0, WR_ADDR=0, WR_DATA=0.
- Derived constants:
  - PPW = 16/PIX_BITS (pixels per word).
  - WPL = H_VISIBLE/PPW (words per line; 36 at defaults).
- Sampling: on each O_CLK edge with O_VISIBLE=1, O_DATA is shifted into the pack register at slot O_X mod PPW. Slot is taken from the low bits of O_X, not a free-running count, so a glitched pixel cannot misalign a line.
- Word completion: when O_X mod PPW = PPW-1 with O_VISIBLE=1, the completed word and address are registered into a pending stage.
  - Address = O_Y*WPL + (O_X div PPW).
  - Constant multiply is acceptable; it reduces to shift-add.
  - The result is truncated to ADDR_W, with the bank bit in the MSB when DOUBLE_BUFFER_EN is defined.
- Push: on the next cycle the pending word is pushed into the FIFO.
- Latency: last pixel sampled on edge N; pending register loaded on edge N+1; FIFO write on edge N+2. WR_VALID is high after edge N+2 when the FIFO was empty (fall-through head register).
- Handshake:
  - The head pops on an edge where WR_VALID & WR_READY.
  - WR_ADDR and WR_DATA hold stable while WR_VALID=1 and WR_READY=0.
  - WR_READY is ignored while WR_VALID=0.
- Simultaneous push and pop at full: allowed; the count is unchanged and nothing is dropped.
- Full without pop: the pending word is dropped and OVERFLOW is set. Existing entries are never corrupted.
- Boundary rules:
  - O_X >= H_VISIBLE or O_Y >= V_VISIBLE is never written, even if O_VISIBLE is asserted.
  - O_VISIBLE falling mid-word discards the partial word; no padded write is issued.
- FRAME_START rising edge (detected against the registered previous value):
  - clears the pack register and OVERFLOW;
  - toggles BANK (DOUBLE_BUFFER_EN only);
  - does not flush the FIFO, because queued writes belong to the finished frame and drain normally.
- FRAME_START and a word completion in the same cycle: the word is still queued. OVERFLOW clear takes priority over set.
- Reset mid-operation: the FIFO is emptied and all in-flight words are lost; this is acceptable.

Optional Feature:
- Macro: DOUBLE_BUFFER_EN.
- Defined:
  - BANK toggles on each FRAME_START rising edge.
  - WR_ADDR MSB = BANK latched at word completion, so a word is tagged with the bank in force when its last pixel was sampled.
  - The reader displays bank ~BANK.
- Not defined:
  - BANK is tied 0 and WR_ADDR MSB = 0.
  - A single buffer is used; tearing is accepted.

Decomposition:
- Shared package holds PIX_BITS, H_VISIBLE, V_VISIBLE, the PPW/WPL derivations and the ADDR_W default, so the VGA-side reader uses identical geometry.
- One sub-module: o_wr_fifo.
  - Synchronous FIFO with fall-through head, carrying ADDR_W+16 bits, depth FIFO_DEPTH.
  - Exposes full, empty and count.

Test Plan:
- Basic pack: PIX_BITS=1, WR_READY=1, line O_Y=0 with O_DATA=1 only at O_X=0 and O_X=17 -> WR_ADDR=0 data 0x0001; WR_ADDR=1 data 0x0002; 36 writes total for the line.
- Addressing: O_Y=2, O_X=575 completing a word -> WR_ADDR=2*36+35=107; O_Y=377 last word -> WR_ADDR=13607.
- Backpressure: WR_READY=0 for a full line -> 4 words queued and held stable, OVERFLOW=1 after the 5th word. FRAME_START pulse -> OVERFLOW=0 while the 4 queued words are retained.
- Full with simultaneous pop: FIFO full, word completion with WR_READY=1 on the same edge -> no drop, OVERFLOW stays 0.
- Partial word: O_VISIBLE deasserted at O_X=7 -> no write issued for that slot range.
- DOUBLE_BUFFER_EN: two FRAME_START pulses -> BANK goes 0→1→0; a frame-1 word at O_Y=0, O_X=15 -> WR_ADDR=0x4000. Async reset mid-frame -> WR_VALID drops immediately and BANK=0.

Source files
------------

// File: rtl/o_pixel_packer_pkg.sv
// Shared scope-side frame-buffer geometry for o_pixel_packer and the VGA-side reader.
// Holds default pixel depth, visible window size, address width and the
// pixels-per-word / words-per-line derivations so both sides agree on layout.
package o_pixel_packer_pkg;

  localparam int PIX_BITS_DEF   = 1;
  localparam int H_VISIBLE_DEF  = 576;
  localparam int V_VISIBLE_DEF  = 378;
  localparam int ADDR_W_DEF     = 15;
  localparam int FIFO_DEPTH_DEF = 4;

  // Pixels packed into one 16-bit frame-buffer word.
  function automatic int calc_ppw(input int pix_bits);
    return 16 / pix_bits;
  endfunction

  // Frame-buffer words per visible line.
  function automatic int calc_wpl(input int h_visible, input int pix_bits);
    return h_visible / calc_ppw(pix_bits);
  endfunction

  // Snapshot of a just-completed word, taken on the edge its last pixel is sampled.
  typedef struct packed {
    logic [15:0] data;
    logic [9:0]  word_x;
    logic [8:0]  y;
    logic        bank;
  } cmpl_t;

endpackage

// File: rtl/o_wr_fifo.sv
// Write-request FIFO with fall-through head. The head entry is presented
// combinationally while non-empty and reads as zero while empty.
// Push while full is refused unless a pop happens on the same edge.
module o_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wr_data,
  input  logic                   pop,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Occupancy, accepted handshakes, pointer advance and head view.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers; clearing them empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are meaningless until written so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/o_pixel_packer.sv
// Packs scope serial video into 16-bit frame-buffer words and queues
// address/data write requests toward the frame-buffer arbiter.
// Pipeline: last pixel sampled (edge N) -> pending word (N+1) -> FIFO (N+2).
// Optional build macro DOUBLE_BUFFER_EN: BANK toggles on each FRAME_START
// rising edge and tags WR_ADDR's MSB; otherwise BANK and the MSB stay 0.
module o_pixel_packer
  import o_pixel_packer_pkg::*;
#(
  parameter int PIX_BITS   = PIX_BITS_DEF,
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic                O_CLK,
  input  logic                RST_N,
  input  logic [9:0]          O_X,
  input  logic [8:0]          O_Y,
  input  logic                O_VISIBLE,
  input  logic [PIX_BITS-1:0] O_DATA,
  input  logic                FRAME_START,
  output logic                WR_VALID,
  input  logic                WR_READY,
  output logic [ADDR_W-1:0]   WR_ADDR,
  output logic [15:0]         WR_DATA,
  output logic                OVERFLOW,
  output logic                BANK
);
  localparam int PPW    = calc_ppw(PIX_BITS);
  localparam int WPL    = calc_wpl(H_VISIBLE, PIX_BITS);
  localparam int SLOT_W = $clog2(PPW);
  localparam int LIN_W  = ADDR_W - 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]       pack_q, pack_d, pack_ins;
  logic              fs_prev_q, fs_prev_d, fs_rise;
  logic              ovf_q, ovf_d;
  logic              bank_q, bank_d;
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  cmpl_t             cmpl_q, cmpl_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [15:0]       pend_data_q, pend_data_d;
  logic [SLOT_W-1:0] slot;
  logic              in_win, word_done;
  logic [LIN_W-1:0]  lin_addr;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_push, drop;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [ADDR_W+15:0] fifo_head;

  // Pixel qualification: slot comes from O_X so a glitch cannot skew later words.
  always_comb begin
    slot      = O_X[SLOT_W-1:0];
    in_win    = O_VISIBLE && (O_X < 10'(H_VISIBLE)) && (O_Y < 9'(V_VISIBLE));
    word_done = in_win & (&slot);
    fs_rise   = FRAME_START & ~fs_prev_q;
    pack_ins  = pack_q;
    pack_ins[int'(slot)*PIX_BITS +: PIX_BITS] = O_DATA;
  end

  // Pack register, frame-start edge tracking and bank selection.
  always_comb begin
    pack_d    = fs_rise ? '0 : (in_win ? pack_ins : pack_q);
    fs_prev_d = FRAME_START;
`ifdef DOUBLE_BUFFER_EN
    bank_d    = bank_q ^ fs_rise;
`else
    bank_d    = 1'b0;
`endif
  end

  // Completion snapshot (edge N) and pending word with its address (edge N+1).
  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], word_done};
    cmpl_d     = cmpl_q;
    if (word_done) begin
      cmpl_d.data   = pack_ins;
      cmpl_d.word_x = O_X >> SLOT_W;
      cmpl_d.y      = O_Y;
      cmpl_d.bank   = bank_q;
    end
    lin_addr    = LIN_W'(cmpl_q.y) * LIN_W'(WPL) + LIN_W'(cmpl_q.word_x);
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    if (vld_pipe_q[0]) begin
      pend_addr_d = {cmpl_q.bank, lin_addr};
      pend_data_d = cmpl_q.data;
    end
  end

  // FIFO push/pop and sticky overflow; a frame start wins over a same-cycle drop.
  always_comb begin
    fifo_pop  = WR_READY & ~fifo_empty;
    drop      = vld_pipe_q[1] & fifo_full & ~fifo_pop;
    fifo_push = vld_pipe_q[1] & ~drop;
    ovf_d     = fs_rise ? 1'b0 : (ovf_q | drop);
  end

  // State registers.
  always_ff @(posedge O_CLK or negedge RST_N) begin
    if (!RST_N) begin
      pack_q      <= '0;
      fs_prev_q   <= 1'b0;
      ovf_q       <= 1'b0;
      bank_q      <= 1'b0;
      vld_pipe_q  <= '0;
      cmpl_q      <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      pack_q      <= pack_d;
      fs_prev_q   <= fs_prev_d;
      ovf_q       <= ovf_d;
      bank_q      <= bank_d;
      vld_pipe_q  <= vld_pipe_d;
      cmpl_q      <= cmpl_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  o_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ADDR_W + 16)
  ) u_fifo (
    .clk     (O_CLK),
    .rst_n   (RST_N),
    .push    (fifo_push),
    .wr_data ({pend_addr_q, pend_data_q}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign WR_VALID = (fifo_cnt != '0);
  assign WR_ADDR  = fifo_head[ADDR_W+15:16];
  assign WR_DATA  = fifo_head[15:0];
  assign OVERFLOW = ovf_q;
  assign BANK     = bank_q;

endmodule

// File: tb/tb_o_pixel_packer.sv
// Bench for o_pixel_packer at default geometry (1 bit/pixel, 576x378, 4-deep FIFO).
// A queue-based reference model derives expected writes from pixel coordinates.
`timescale 1ns/1ps
module tb_o_pixel_packer;
  localparam int PIX_BITS = 1;
  localparam int H_VIS    = 576;
  localparam int V_VIS    = 378;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 15;
  localparam int PPW      = 16;
  localparam int WPL      = 36;

  logic                O_CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic [9:0]          O_X = '0;
  logic [8:0]          O_Y = '0;
  logic                O_VISIBLE = 1'b0;
  logic [PIX_BITS-1:0] O_DATA = '0;
  logic                FRAME_START = 1'b0;
  logic                WR_VALID;
  logic                WR_READY = 1'b0;
  logic [ADDR_W-1:0]   WR_ADDR;
  logic [15:0]         WR_DATA;
  logic                OVERFLOW;
  logic                BANK;

  o_pixel_packer #(
    .PIX_BITS(PIX_BITS), .H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS),
    .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .O_CLK(O_CLK), .RST_N(RST_N), .O_X(O_X), .O_Y(O_Y), .O_VISIBLE(O_VISIBLE),
    .O_DATA(O_DATA), .FRAME_START(FRAME_START), .WR_VALID(WR_VALID),
    .WR_READY(WR_READY), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .OVERFLOW(OVERFLOW), .BANK(BANK)
  );

  always #5 O_CLK = ~O_CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [ADDR_W-1:0] addr; logic [15:0] data; } wr_t;
  wr_t mq[$];
  bit  m_ovf, m_bank, m_fs_prev;
  bit  d1_v, d2_v, ev_v;
  wr_t d1, d2, ev;
  bit  lp [0:1023];

  always @(posedge O_CLK or negedge RST_N) begin
    if (!RST_N) begin
      mq.delete();
      m_ovf = 0; m_bank = 0; m_fs_prev = 0; d1_v = 0; d2_v = 0;
    end else begin
      if (mq.size() > 0 && WR_READY) void'(mq.pop_front());
      if (d2_v) begin
        if (mq.size() < DEPTH) mq.push_back(d2);
        else m_ovf = 1;
      end
      ev_v = 0;
      ev   = '0;
      if (O_VISIBLE && int'(O_X) < H_VIS && int'(O_Y) < V_VIS) begin
        lp[int'(O_X)] = O_DATA[0];
        if (int'(O_X) % PPW == PPW - 1) begin
          ev_v = 1;
          for (int k = 0; k < 16; k++) ev.data[k] = lp[int'(O_X) - 15 + k];
          ev.addr = ADDR_W'(int'(O_Y) * WPL + int'(O_X) / PPW);
          ev.addr[ADDR_W-1] = m_bank;
        end
      end
      if (FRAME_START && !m_fs_prev) begin
        m_ovf = 0;
`ifdef DOUBLE_BUFFER_EN
        m_bank = ~m_bank;
`endif
      end
      m_fs_prev = FRAME_START;
      d2_v = d1_v; d2 = d1;
      d1_v = ev_v; d1 = ev;
    end
  end

  // ---------------- per-cycle compare + pop log ----------------
  logic [30:0] log_q[$];

  always @(negedge O_CLK) begin
    check("valid", {31'd0, WR_VALID}, {31'd0, mq.size() > 0});
    check("addr", {17'd0, WR_ADDR}, (mq.size() > 0) ? {17'd0, mq[0].addr} : 32'd0);
    check("data", {16'd0, WR_DATA}, (mq.size() > 0) ? {16'd0, mq[0].data} : 32'd0);
    check("overflow", {31'd0, OVERFLOW}, {31'd0, m_ovf});
    check("bank", {31'd0, BANK}, {31'd0, m_bank});
    if (RST_N && WR_VALID && WR_READY) log_q.push_back({WR_ADDR, WR_DATA});
  end

  // ---------------- stimulus ----------------
  bit pat [0:1023];

  task automatic step(input bit vis, input int x, input int y, input bit d,
                      input bit fs, input bit rdy);
    O_VISIBLE   = vis;
    O_X         = 10'(x);
    O_Y         = 9'(y);
    O_DATA      = PIX_BITS'(d);
    FRAME_START = fs;
    WR_READY    = rdy;
    @(posedge O_CLK);
    #1;
  endtask

  task automatic idle(input int n, input int rdy_mode);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, (rdy_mode == 2) ? bit'($urandom_range(0, 1)) : bit'(rdy_mode));
  endtask

  // rdy_mode: 0 = stalled, 1 = always ready, 2 = random
  task automatic drive_run(input int y, input int x0, input int x1, input int cut,
                           input int rdy_mode, input bit fs_last);
    for (int x = x0; x <= x1; x++) begin
      bit rdy;
      rdy = (rdy_mode == 2) ? bit'($urandom_range(0, 1)) : bit'(rdy_mode);
      step(x < cut, x, y, pat[x], fs_last && (x == x1), rdy);
    end
  endtask

  task automatic fs_pulse();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_log_addr(input string name, input int idx, input int exp);
    if (log_q.size() > idx) check(name, {17'd0, log_q[idx][30:16]}, exp);
    else check(name, 32'hFFFF_FFFF, exp);
  endtask

  initial begin
    repeat (3) @(posedge O_CLK);
    #1;
    check("rst_valid", {31'd0, WR_VALID}, 0);
    check("rst_addr", {17'd0, WR_ADDR}, 0);
    check("rst_data", {16'd0, WR_DATA}, 0);
    check("rst_ovf", {31'd0, OVERFLOW}, 0);
    check("rst_bank", {31'd0, BANK}, 0);
    RST_N = 1'b1;
    idle(2, 1);

    // Basic pack: only pixels 0 and 17 lit on line 0.
    for (int i = 0; i < 1024; i++) pat[i] = 0;
    pat[0] = 1; pat[17] = 1;
    log_q.delete();
    drive_run(0, 0, 575, 1024, 1, 0);
    idle(10, 1);
    check("basic_count", log_q.size(), 36);
    check_log_addr("basic_w0_addr", 0, 0);
    check_log_addr("basic_w1_addr", 1, 1);
    if (log_q.size() > 1) begin
      check("basic_w0_data", {16'd0, log_q[0][15:0]}, 32'h0001);
      check("basic_w1_data", {16'd0, log_q[1][15:0]}, 32'h0002);
    end else check("basic_data_present", log_q.size(), 2);

    // Addressing at line ends.
    for (int i = 0; i < 1024; i++) pat[i] = bit'($urandom_range(0, 1));
    log_q.delete();
    drive_run(2, 560, 575, 1024, 1, 0);
    drive_run(377, 560, 575, 1024, 1, 0);
    idle(8, 1);
    check("addr_count", log_q.size(), 2);
    check_log_addr("addr_y2_last", 0, 107);
    check_log_addr("addr_y377_last", 1, 13607);

    // Backpressure for a whole line, then frame start clears overflow only.
    log_q.delete();
    drive_run(3, 0, 575, 1024, 0, 0);
    idle(5, 0);
    check("bp_valid", {31'd0, WR_VALID}, 1);
    check("bp_head", {17'd0, WR_ADDR}, 108);
    check("bp_ovf", {31'd0, OVERFLOW}, 1);
    idle(3, 0);
    check("bp_head_hold", {17'd0, WR_ADDR}, 108);
    fs_pulse();
    check("bp_ovf_clr", {31'd0, OVERFLOW}, 0);
    check("bp_retained", {17'd0, WR_ADDR}, 108);
    idle(10, 1);
    check("bp_drain_count", log_q.size(), 4);
    check_log_addr("bp_drain_last", 3, 111);

    // Full FIFO with a push landing on the same edge as a pop.
    log_q.delete();
    drive_run(4, 0, 63, 1024, 0, 0);
    idle(4, 0);
    drive_run(4, 64, 79, 1024, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(3, 0);
    check("full_pop_ovf", {31'd0, OVERFLOW}, 0);
    check("full_pop_head", {17'd0, WR_ADDR}, 145);
    idle(10, 1);
    check("full_pop_count", log_q.size(), 5);
    check_log_addr("full_pop_last", 4, 148);

    // Partial word and out-of-window pixels produce nothing.
    log_q.delete();
    drive_run(5, 0, 31, 7, 1, 0);
    drive_run(6, 576, 591, 1024, 1, 0);
    drive_run(378, 0, 15, 1024, 1, 0);
    idle(6, 1);
    check("partial_none", log_q.size(), 0);

    // Randomised runs, random backpressure and frame starts.
    for (int r = 0; r < 60; r++) begin
      int y, x0, x1, cut, rm;
      y  = $urandom_range(0, V_VIS - 1);
      x0 = 16 * $urandom_range(0, WPL - 1);
      x1 = x0 + 16 * $urandom_range(1, 4) - 1;
      cut = ($urandom_range(0, 3) == 0) ? $urandom_range(x0, x1) : 1024;
      rm = ($urandom_range(0, 4) == 0) ? 0 : 2;
      for (int x = x0; x <= x1; x++) pat[x] = bit'($urandom_range(0, 1));
      drive_run(y, x0, x1, cut, rm, $urandom_range(0, 4) == 0);
      idle($urandom_range(0, 3), 2);
    end
    idle(20, 1);

    // Asynchronous reset mid-operation.
    drive_run(10, 0, 31, 1024, 0, 0);
    idle(3, 0);
    check("pre_rst_valid", {31'd0, WR_VALID}, 1);
    #2 RST_N = 1'b0;
    #1;
    check("midrst_valid", {31'd0, WR_VALID}, 0);
    check("midrst_bank", {31'd0, BANK}, 0);
    check("midrst_ovf", {31'd0, OVERFLOW}, 0);
    @(posedge O_CLK); #1;
    RST_N = 1'b1;
    idle(3, 1);

`ifdef DOUBLE_BUFFER_EN
    fs_pulse();
    check("db_bank1", {31'd0, BANK}, 1);
    fs_pulse();
    check("db_bank0", {31'd0, BANK}, 0);
    fs_pulse();
    drive_run(0, 0, 15, 1024, 0, 0);
    idle(4, 0);
    check("db_addr", {17'd0, WR_ADDR}, 32'h4000);
    #2 RST_N = 1'b0;
    #1;
    check("db_rst_valid", {31'd0, WR_VALID}, 0);
    check("db_rst_bank", {31'd0, BANK}, 0);
    @(posedge O_CLK); #1;
    RST_N = 1'b1;
    idle(3, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
